// File: rtl/mem_pkg.sv
// Shared constants and state type for the mem_initiator memory controller.
package mem_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StDrain,
    StClear
  } state_e;

endpackage

// File: rtl/mem_initiator_if.sv
// Client command/data channels plus the memory port of mem_initiator.
// master: client and memory model side; slave: the initiator itself.
interface mem_initiator_if #(
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_pkg::DATA_W,
  parameter int unsigned LEN_W  = mem_pkg::LEN_W
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;

  logic              wdat_valid;
  logic              wdat_ready;
  logic [DATA_W-1:0] wdat_data;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_last;

  logic              cmd_done;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;

  modport master (
    output req_valid, req_we, req_addr, req_len,
    output wdat_valid, wdat_data,
    output rsp_ready,
    output mem_dout,
    input  req_ready, wdat_ready, rsp_valid, rsp_data, rsp_last, cmd_done,
    input  mem_we, mem_addr, mem_din
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_len,
    input  wdat_valid, wdat_data,
    input  rsp_ready,
    input  mem_dout,
    output req_ready, wdat_ready, rsp_valid, rsp_data, rsp_last, cmd_done,
    output mem_we, mem_addr, mem_din
  );

endinterface

// File: rtl/mem_rsp_slot.sv
// Single-entry response register; accepts a new beat whenever it is empty
// or its current beat is being taken in the same cycle.
module mem_rsp_slot #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  input  logic              last_in,
  input  logic              ready,
  output logic              free,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last
);

  logic              valid_q;
  logic              last_q;
  logic [DATA_W-1:0] data_q;

  assign free  = !valid_q || ready;
  assign valid = valid_q;
  assign last  = last_q;
  assign data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else if (free) begin
      if (load) begin
        valid_q <= 1'b1;
        last_q  <= last_in;
        data_q  <= data_in;
      end else begin
        // Beat taken with nothing behind it; data is left as is.
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_initiator.sv
// Burst read/write sequencer for a sync-write, comb-read memory.
// MEM_INIT_CLEAR_EN adds a zero-fill pass over the whole memory out of reset.
module mem_initiator #(
  parameter int unsigned ADDR_W = mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mem_pkg::DATA_W,
  parameter int unsigned LEN_W  = mem_pkg::LEN_W
) (
  input logic            clk,
  input logic            rst_n,
  mem_initiator_if.slave bus
);

  import mem_pkg::*;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;

  logic              slot_load;
  logic              slot_free;
  logic              slot_valid;
  logic              slot_last;
  logic [DATA_W-1:0] slot_data;

`ifdef MEM_INIT_CLEAR_EN
  localparam state_e ResetState = StClear;
`else
  localparam state_e ResetState = StIdle;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ResetState;
      addr_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    cnt_d          = cnt_q;
    done_d         = 1'b0;
    slot_load      = 1'b0;
    bus.req_ready  = 1'b0;
    bus.wdat_ready = 1'b0;
    bus.mem_we     = 1'b0;
    bus.mem_din    = '0;
    unique case (state_q)
      StIdle: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          cnt_d   = bus.req_len;
          state_d = bus.req_we ? StWrite : StRead;
        end
      end
      StWrite: begin
        bus.wdat_ready = 1'b1;
        bus.mem_we     = bus.wdat_valid;
        bus.mem_din    = bus.wdat_data;
        if (bus.wdat_valid) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == '0) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StRead: begin
        slot_load = slot_free;
        if (slot_free) begin
          addr_d = addr_q + ADDR_W'(1);
          cnt_d  = cnt_q - LEN_W'(1);
          if (cnt_q == '0) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        // Hold off new commands until the final read beat has been taken.
        if (slot_free) begin
          state_d = StIdle;
        end
      end
`ifdef MEM_INIT_CLEAR_EN
      StClear: begin
        bus.mem_we = 1'b1;
        addr_d     = addr_q + ADDR_W'(1);
        if (addr_q == '1) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  mem_rsp_slot #(
    .DATA_W (DATA_W)
  ) u_rsp_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (slot_load),
    .data_in (bus.mem_dout),
    .last_in (cnt_q == '0),
    .ready   (bus.rsp_ready),
    .free    (slot_free),
    .valid   (slot_valid),
    .data    (slot_data),
    .last    (slot_last)
  );

  assign bus.rsp_valid = slot_valid;
  assign bus.rsp_data  = slot_data;
  assign bus.rsp_last  = slot_last;
  assign bus.cmd_done  = done_q;
  assign bus.mem_addr  = addr_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Randomized bench for mem_initiator against a burst-level memory model.
module tb_mem_initiator;

  logic clk;
  logic rst_n;

  mem_initiator_if bus ();

  mem_initiator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory instance model: synchronous write, combinational read.
  logic [31:0] mem [1024];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
  assign bus.mem_dout = mem[bus.mem_addr];

  // Reference contents, updated per burst beat; unknown words are not checked.
  logic [31:0] ref_mem   [1024];
  bit          ref_known [1024];

  int n_vec = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] wrap(input logic [9:0] base, input int off);
    return 10'((int'(base) + off) % 1024);
  endfunction

  task automatic wait_ready();
    int cyc = 0;
    while (!bus.req_ready && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
`ifdef MEM_INIT_CLEAR_EN
    check("clear_cycles", cyc, 1024);
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i]   = '0;
      ref_known[i] = 1'b1;
    end
`else
    check("ready_after_reset", cyc, 0);
`endif
  endtask

  // gap: 0 none, 1 single idle before beat 2, 2 random idles.
  task automatic do_write(input logic [9:0] addr, input logic [3:0] len, input int gap,
                          input logic [31:0] dbase, input bit rnd);
    int          i = 0;
    int          we_cnt = 0;
    int          guard = 0;
    bit          gapped = 0;
    bit          give;
    logic [31:0] d;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = addr;
    bus.req_len    = len;
    bus.wdat_valid = 1'b1;  // ignored while idle
    bus.wdat_data  = 32'hDEAD_BEEF;
    #1;
    check("wr_req_ready", bus.req_ready, 1);
    check("wr_idle_we", bus.mem_we, 0);
    check("wr_idle_wdat_ready", bus.wdat_ready, 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    while (i <= int'(len) && guard < 100) begin
      guard++;
      case (gap)
        0:       give = 1'b1;
        1:       give = !(i == 2 && !gapped);
        default: give = ($urandom_range(0, 3) != 0);
      endcase
      if (!give) gapped = 1'b1;
      d = rnd ? 32'($urandom) : dbase + 32'(i);
      bus.wdat_valid = give;
      bus.wdat_data  = d;
      #1;
      check("wdat_ready", bus.wdat_ready, 1);
      check("wr_mem_we", bus.mem_we, give);
      if (bus.mem_we) we_cnt++;
      if (give) begin
        check("wr_mem_addr", bus.mem_addr, wrap(addr, i));
        check("wr_mem_din", bus.mem_din, d);
        ref_mem[wrap(addr, i)]   = d;
        ref_known[wrap(addr, i)] = 1'b1;
        i++;
      end
      @(negedge clk);
    end
    bus.wdat_valid = 1'b0;
    check("wr_beats", i, int'(len) + 1);
    check("wr_we_cycles", we_cnt, int'(len) + 1);
    check("cmd_done_pulse", bus.cmd_done, 1);
    check("wr_req_ready_back", bus.req_ready, 1);
    check("wr_after_we", bus.mem_we, 0);
    @(negedge clk);
    check("cmd_done_clear", bus.cmd_done, 0);
  endtask

  // mode: 0 always ready, 1 random stalls, 2 two-cycle stalls on beats 1 and 3.
  task automatic do_read(input logic [9:0] addr, input logic [3:0] len, input int mode);
    int         k = 0;
    int         held = 0;
    int         guard = 0;
    logic       rdy;
    logic [9:0] a;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.rsp_ready = 1'b0;
    #1;
    check("rd_req_ready", bus.req_ready, 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("rd_latency", bus.rsp_valid, 0);
    @(negedge clk);
    while (k <= int'(len) && guard < 200) begin
      guard++;
      a = wrap(addr, k);
      check("rsp_valid", bus.rsp_valid, 1);
      check("rd_req_ready_busy", bus.req_ready, 0);
      check("rd_mem_we", bus.mem_we, 0);
      if (ref_known[a]) check("rsp_data", bus.rsp_data, ref_mem[a]);
      check("rsp_last", bus.rsp_last, k == int'(len));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 2) != 0);
        default: rdy = !((k == 1 || k == 3) && held < 2);
      endcase
      bus.rsp_ready = rdy;
      if (rdy) begin
        k++;
        held = 0;
      end else begin
        held++;
      end
      @(negedge clk);
    end
    bus.rsp_ready = 1'b0;
    check("rd_beats", k, int'(len) + 1);
    check("rsp_valid_end", bus.rsp_valid, 0);
    check("rd_req_ready_end", bus.req_ready, 1);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_len    = '0;
    bus.wdat_valid = 1'b0;
    bus.wdat_data  = '0;
    bus.rsp_ready  = 1'b0;
    for (int i = 0; i < 1024; i++) begin
      ref_mem[i]   = '0;
      ref_known[i] = 1'b0;
    end
    #1;
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_data", bus.rsp_data, 0);
    check("rst_rsp_last", bus.rsp_last, 0);
    check("rst_cmd_done", bus.cmd_done, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_wdat_ready", bus.wdat_ready, 0);
`ifdef MEM_INIT_CLEAR_EN
    check("rst_req_ready", bus.req_ready, 0);
`else
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_mem_we", bus.mem_we, 0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready();

`ifdef MEM_INIT_CLEAR_EN
    do_read(10'h2A5, 4'd0, 0);
`endif
    do_write(10'h010, 4'd3, 1, 32'h0000_00A0, 1'b0);
    do_read(10'h010, 4'd3, 0);
    do_read(10'h010, 4'd3, 2);
    do_write(10'h3FE, 4'd3, 0, 32'h0000_00B0, 1'b0);
    do_read(10'h3FE, 4'd3, 1);
    do_write(10'd1020, 4'd15, 2, 32'h0, 1'b1);
    do_read(10'd1020, 4'd15, 0);
    do_write(10'h055, 4'd0, 0, 32'h1234_5678, 1'b0);
    do_read(10'h055, 4'd0, 2);

    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)), 2, 32'h0, 1'b1);
      else
        do_read(10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)), 1);
    end

    // Abort a len=7 read while beat 2 is being presented.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = 10'h100;
    bus.req_len   = 4'd7;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_pre_valid", bus.rsp_valid, 1);
      check("abort_pre_last", bus.rsp_last, 0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_rsp_last", bus.rsp_last, 0);
    check("abort_mem_addr", bus.mem_addr, 0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    rst_n = 1'b1;
    wait_ready();
    do_read(10'h3FF, 4'd0, 0);
`ifdef MEM_INIT_CLEAR_EN
    do_read(10'h2A5, 4'd0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_initiator.md
Name: mem_initiator

Overview:
- Initiator/controller for the team's single-port synchronous-write, combinational-read 1024x32 memory.
- Accepts burst read/write commands from a client over valid/ready, sequences addresses onto the memory port, and streams write data in and read data out.
- Sits between datapath clients and the memory instance; it is the only driver of the memory's we/addr/din.

Parameters:
- ADDR_W, 10, memory address width (depth = 2**ADDR_W).
- DATA_W, 32, data word width.
- LEN_W, 4, burst length field width; a burst is len+1 beats (1..16).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  high only in IDLE.
- req_we  in  1  1 = write burst, 0 = read burst.
- req_addr  in  ADDR_W  start address.
- req_len  in  LEN_W  beats minus one.
- wdat_valid  in  1  write beat valid.
- wdat_ready  out  1  high only in WRITE.
- wdat_data  in  DATA_W  write beat data.
- rsp_valid  out  1  read beat valid.
- rsp_ready  in  1  client accepts read beat.
- rsp_data  out  DATA_W  read beat data.
- rsp_last  out  1  marks final read beat of a burst.
- cmd_done  out  1  one-cycle pulse when a write burst completes.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address (registered).
- mem_din  out  DATA_W  memory write data.
- mem_dout  in  DATA_W  memory read data, combinational from mem_addr.

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_addr=0, beat counter=0, rsp_valid=0, rsp_data=0, rsp_last=0, cmd_done=0. mem_we=0 and wdat_ready=0 follow from IDLE.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE:
  - req_ready=1.
  - On req_valid, latch mem_addr<=req_addr and cnt<=req_len.
  - Go to WRITE if req_we, else READ.
- WRITE:
  - wdat_ready=1; mem_we=wdat_valid; mem_din=wdat_data (both combinational). The memory captures on the same edge as the handshake.
  - Each beat: mem_addr+1 (mod 2**ADDR_W, 1023 wraps to 0), cnt-1.
  - On the beat with cnt==0: go to IDLE and assert cmd_done for the next cycle only.
  - No wdat beat: hold state and address.
- READ:
  - Slot free when !rsp_valid || rsp_ready.
  - If free: rsp_data<=mem_dout, rsp_valid<=1, rsp_last<=(cnt==0), mem_addr+1 (wrap), cnt-1.
  - After the cnt==0 capture, go to DRAIN.
  - If not free: hold everything; rsp_data is stable while rsp_valid && !rsp_ready.
- DRAIN:
  - Wait for rsp_ready on the last beat, clear rsp_valid/rsp_last, go to IDLE.
  - req_ready stays low until IDLE, so a new command cannot overtake an unaccepted read beat.
- Latency:
  - Read: req accept at edge N -> first rsp_valid after edge N+1.
  - Full-throughput rsp_ready=1 gives one beat per cycle.
- mem_we is never 1 outside WRITE.
- Write data beats presented outside WRITE are ignored (wdat_ready=0).
- req_len=0 gives a single beat. len=15 from 1020 touches 1020..1023,0..11.
- Reset mid-burst aborts immediately: the partial write stays in memory, and the pending read beat is discarded.

Optional Feature:
- Macro MEM_INIT_CLEAR_EN.
- Defined:
  - Extra state CLEAR entered out of reset.
  - Writes 0 to addresses 0..2**ADDR_W-1, one per cycle (mem_we=1, mem_din=0); req_ready=0 throughout.
  - Then IDLE; first req_ready after 1024 cycles with the default parameters.
  - Reset during CLEAR restarts at address 0.
- Undefined: CLEAR state absent; IDLE directly after reset; memory contents undefined.

Decomposition:
- Package mem_pkg: ADDR_W/DATA_W/LEN_W default constants; state enum type (IDLE, WRITE, READ, DRAIN, CLEAR).
- One natural sub-module: mem_rsp_slot.
  - Single-entry output register holding data/last/valid with the free = !valid || ready rule.
  - Instantiated once for the response channel.

Test Plan:
- Write burst: addr=0x010, len=3, data A0..A3 with a one-cycle wdat_valid gap after beat 1 -> mem_we exactly 4 cycles at 0x010..0x013; cmd_done one pulse; req_ready back high.
- Read burst, rsp_ready=1: read addr=0x010, len=3 after the prior write -> rsp_data A0..A3 on consecutive cycles, first valid at N+2, rsp_last only on A3.
- Backpressure: same read with rsp_ready low on beats 1 and 3 for 2 cycles each -> rsp_data/rsp_last stable while stalled; no beats lost or duplicated; req_ready stays low until the last beat is accepted.
- Wrap: write len=3 from 0x3FE (B0..B3), then read back -> locations 0x3FE, 0x3FF, 0x000, 0x001 hold B0..B3.
- Reset mid-operation: rst_n low during beat 2 of a len=7 read -> rsp_valid drops asynchronously; IDLE after release; a new single read at 0x3FF returns the correct word.
- With MEM_INIT_CLEAR_EN: read 0x2A5 on the first req_ready -> 0x00000000; req_ready first high 1024 cycles after reset release.
